// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   XLEN_DEFAULT  : default datapath / address width
//   NOP_INSTR     : canonical RISC-V NOP (addi x0, x0, 0) used for bubbles
//   fetch_state_t : fetch control state (BOOT, RUN, DRAIN)
//   if_id_t       : IF/ID pipeline register layout at the default XLEN, as
//                   seen by the decode stage
// ---------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        DRAIN
    } fetch_state_t;

    typedef struct packed {
        logic                    valid;
        logic [31:0]             instr;
        logic [XLEN_DEFAULT-1:0] pc;
        logic [XLEN_DEFAULT-1:0] pc_plus4;
    } if_id_t;

    // Saturating 32-bit increment for event counters.
    function automatic logic [31:0] sat_inc32(input logic [31:0] value);
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Parameterised synchronous FIFO with a synchronous clear.
//   WIDTH, DEPTH : entry width and entry count (DEPTH a power of 2, >= 2)
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   clr               : synchronous clear, wins over push and pop
//   push, push_data   : write an entry (ignored when full unless popping)
//   pop, pop_data     : remove the head; pop_data always shows the head
//   full, empty, count: occupancy status
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic             do_push;
    logic             do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign count    = cnt_q;
    assign pop_data = mem[rd_ptr_q];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of block order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (clr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // NOTE: storage is not reset; the pointers and count define which entries
    // are meaningful, so resetting the array would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (do_push && !clr) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage of the 5-stage in-order core. Owns the PC, issues
// in-order requests to instruction memory, buffers returned words and drives
// the IF/ID pipeline register toward decode.
//
// Parameters: XLEN (address width), RESET_PC, BUF_DEPTH (max requests in
// flight plus buffered instructions; power of 2, >= 2).
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   stall_fetch_i                 : freeze PC, issue no new requests
//   stall_decode_i                : hold IF/ID
//   flush_decode_i                : kill IF/ID contents
//   redirect_valid_i/redirect_pc_i: taken branch/jump from execute
//   imem_req_valid_o/ready_i/addr_o : request channel (valid/ready)
//   imem_rsp_valid_i/data_i       : in-order response channel (valid only)
//   valid_dec_o, instr_dec_o, pc_dec_o, pc_plus4_dec_o : IF/ID register
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
// perf_bubble_cnt_o (bubbles loaded, flush excluded) and perf_redirect_cnt_o.
// ---------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN      = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int unsigned     BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_fetch_i,
    input  logic            stall_decode_i,
    input  logic            flush_decode_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            valid_dec_o,
    output logic [31:0]     instr_dec_o,
    output logic [XLEN-1:0] pc_dec_o,
    output logic [XLEN-1:0] pc_plus4_dec_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     perf_bubble_cnt_o,
    output logic [31:0]     perf_redirect_cnt_o
`endif
);

    localparam int unsigned   CW        = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(BUF_DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [31:0]     instr;
    } fetch_entry_t;

    typedef struct packed {
        logic         valid;
        fetch_entry_t entry;
    } if_id_reg_t;

    localparam if_id_reg_t BUBBLE = '{
        valid: 1'b0,
        entry: '{pc: '0, pc_plus4: '0, instr: NOP_INSTR}
    };

    fetch_state_t  state_q;
    logic [XLEN-1:0] pc_q;
    logic [CW-1:0] drop_q;
    if_id_reg_t    if_id_q;

    logic [CW-1:0]   inflight_cnt;
    logic [CW-1:0]   buf_cnt;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight_full;
    logic            inflight_empty;
    logic            buf_full;
    logic            buf_empty;
    fetch_entry_t    buf_head;
    fetch_entry_t    rsp_entry;

    logic          req_valid;
    logic          req_fire;
    logic          rsp_keep;
    logic          rsp_drop;
    logic [CW-1:0] redirect_drop;
    logic          if_load;
    logic          take_head;
    logic          take_rsp;
    logic          buf_push;
    logic          unused_flags;

    assign unused_flags = &{1'b0, inflight_full, inflight_empty, buf_full};

    // ------------------------------------------------------------------
    // Request issue. Occupancy counts slots already promised to the
    // buffer, so an accepted request always has room for its response.
    // Only registered counts feed this, never the response channel.
    // ------------------------------------------------------------------
    assign req_valid = (state_q != BOOT) && !stall_fetch_i && !redirect_valid_i &&
                       (({1'b0, inflight_cnt} + {1'b0, buf_cnt}) < DEPTH_LIM);
    assign req_fire  = req_valid && imem_req_ready_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;

    // ------------------------------------------------------------------
    // Response handling. Stale responses (drop_q > 0, or any response in a
    // redirect cycle) are consumed without reaching the buffer.
    // ------------------------------------------------------------------
    assign rsp_keep = imem_rsp_valid_i && (drop_q == '0) && !redirect_valid_i;
    assign rsp_drop = imem_rsp_valid_i && (drop_q != '0) && !redirect_valid_i;

    // The response arriving in the redirect cycle is already gone, so it
    // is not counted among the requests still to be dropped.
    assign redirect_drop = inflight_cnt - CW'(imem_rsp_valid_i);

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        rsp_entry          = '0;
        rsp_entry.pc       = inflight_pc;
        rsp_entry.pc_plus4 = inflight_pc + XLEN'(4);
        rsp_entry.instr    = imem_rsp_data_i;
    end

    // IF/ID takes the buffer head first; with an empty buffer a kept
    // response bypasses straight into IF/ID for single-cycle latency.
    // In a redirect cycle the buffer holds wrong-path work, so nothing
    // is taken from it.
    assign if_load   = !flush_decode_i && !stall_decode_i;
    assign take_head = if_load && !buf_empty && !redirect_valid_i;
    assign take_rsp  = if_load && buf_empty && rsp_keep;
    assign buf_push  = rsp_keep && !take_rsp;

    fetch_fifo #(
        .WIDTH (XLEN),
        .DEPTH (BUF_DEPTH)
    ) u_inflight_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (1'b0),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (imem_rsp_valid_i),
        .pop_data  (inflight_pc),
        .full      (inflight_full),
        .empty     (inflight_empty),
        .count     (inflight_cnt)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (redirect_valid_i),
        .push      (buf_push),
        .push_data (rsp_entry),
        .pop       (take_head),
        .pop_data  (buf_head),
        .full      (buf_full),
        .empty     (buf_empty),
        .count     (buf_cnt)
    );

    // ------------------------------------------------------------------
    // Control FSM with PC and drop counter. Redirect overrides everything,
    // including stall_fetch_i.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            drop_q  <= '0;
        end else begin
            if (redirect_valid_i) begin
                pc_q   <= redirect_pc_i;
                drop_q <= redirect_drop;
            end else begin
                if (req_fire) pc_q   <= pc_q + XLEN'(4);
                if (rsp_drop) drop_q <= drop_q - CW'(1);
            end

            unique case (state_q)
                BOOT: state_q <= RUN;
                RUN: begin
                    if (redirect_valid_i && (redirect_drop != '0)) state_q <= DRAIN;
                end
                DRAIN: begin
                    if (redirect_valid_i) begin
                        state_q <= (redirect_drop != '0) ? DRAIN : RUN;
                    end else if ((drop_q == '0) || (rsp_drop && (drop_q == CW'(1)))) begin
                        state_q <= RUN;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // IF/ID register: flush, then stall, then load head / bypass / bubble.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q <= BUBBLE;
        end else if (flush_decode_i) begin
            if_id_q <= BUBBLE;
        end else if (!stall_decode_i) begin
            if (take_head) begin
                if_id_q <= '{valid: 1'b1, entry: buf_head};
            end else if (take_rsp) begin
                if_id_q <= '{valid: 1'b1, entry: rsp_entry};
            end else begin
                if_id_q <= BUBBLE;
            end
        end
    end

    assign valid_dec_o    = if_id_q.valid;
    assign instr_dec_o    = if_id_q.entry.instr;
    assign pc_dec_o       = if_id_q.entry.pc;
    assign pc_plus4_dec_o = if_id_q.entry.pc_plus4;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] bubble_cnt_q;
    logic [31:0] redirect_cnt_q;
    logic        load_bubble;

    assign load_bubble = if_load && !take_head && !take_rsp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q   <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (load_bubble)      bubble_cnt_q   <= sat_inc32(bubble_cnt_q);
            if (redirect_valid_i) redirect_cnt_q <= sat_inc32(redirect_cnt_q);
        end
    end

    assign perf_bubble_cnt_o   = bubble_cnt_q;
    assign perf_redirect_cnt_o = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
// Self-checking bench for fetch_stage. A queue-based model of the fetch
// rules predicts every output each cycle; an in-order memory model answers
// requests with configurable latency. Directed phases pin key literals.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_fetch_i, stall_decode_i, flush_decode_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_valid_o, imem_req_ready_i;
    logic [31:0] imem_req_addr_o;
    logic        imem_rsp_valid_i;
    logic [31:0] imem_rsp_data_i;
    logic        valid_dec_o;
    logic [31:0] instr_dec_o, pc_dec_o, pc_plus4_dec_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_bubble_cnt_o, perf_redirect_cnt_o;
`endif

    always #5 clk = ~clk;

    fetch_stage #(
        .XLEN      (32),
        .RESET_PC  (RESET_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall_fetch_i    (stall_fetch_i),
        .stall_decode_i   (stall_decode_i),
        .flush_decode_i   (flush_decode_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .valid_dec_o      (valid_dec_o),
        .instr_dec_o      (instr_dec_o),
        .pc_dec_o         (pc_dec_o),
        .pc_plus4_dec_o   (pc_plus4_dec_o)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_bubble_cnt_o   (perf_bubble_cnt_o),
        .perf_redirect_cnt_o (perf_redirect_cnt_o)
`endif
    );

    typedef struct {
        bit          valid;
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc4;
    } ifid_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    localparam ifid_t BUBBLE = '{valid: 1'b0, instr: NOP, pc: 32'h0, pc4: 32'h0};

    // Reference model state
    logic [31:0] m_pc;
    bit          m_boot;
    int          m_drop;
    logic [31:0] m_infl[$];
    ifid_t       m_buf[$];
    ifid_t       m_ifid;
    mreq_t       mem_q[$];
    int          last_due;
    int          cyc;

    // Values observed in the current cycle
    logic        obs_req, obs_vd;
    logic [31:0] obs_addr, obs_instr, obs_pc, obs_pc4;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h0010_0093;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_pc   = RESET_PC;
        m_boot = 1'b1;
        m_drop = 0;
        m_infl.delete();
        m_buf.delete();
        m_ifid = BUBBLE;
        mem_q.delete();
        last_due = -1;
        cyc = 0;
    endtask

    task automatic drive_idle();
        stall_fetch_i    = 1'b0;
        stall_decode_i   = 1'b0;
        flush_decode_i   = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i    = 32'h0;
        imem_req_ready_i = 1'b0;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_valid"}, imem_req_valid_o, 32'h0);
        check({tag, "_valid_dec"}, valid_dec_o, 32'h0);
        check({tag, "_instr_dec"}, instr_dec_o, NOP);
        check({tag, "_pc_dec"}, pc_dec_o, 32'h0);
        check({tag, "_pc_plus4_dec"}, pc_plus4_dec_o, 32'h0);
    endtask

    // One clock cycle: called at a negedge, drives inputs, compares all
    // outputs against the model, advances the model, returns at next negedge.
    task automatic cycle(input bit sf, input bit sd, input bit fl, input bit rd,
                         input logic [31:0] rpc, input bit rdy, input int lat);
        bit          exp_req, rsp, keep, fire;
        logic [31:0] rsp_pc;
        ifid_t       ent;
        int          due;

        stall_fetch_i    = sf;
        stall_decode_i   = sd;
        flush_decode_i   = fl;
        redirect_valid_i = rd;
        redirect_pc_i    = rpc;
        imem_req_ready_i = rdy;
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        imem_rsp_valid_i = rsp;
        imem_rsp_data_i  = rsp ? word(mem_q[0].addr) : $urandom();
        #1;

        obs_req   = imem_req_valid_o;
        obs_addr  = imem_req_addr_o;
        obs_vd    = valid_dec_o;
        obs_instr = instr_dec_o;
        obs_pc    = pc_dec_o;
        obs_pc4   = pc_plus4_dec_o;

        exp_req = !m_boot && !sf && !rd && ((m_infl.size() + m_buf.size()) < DEPTH);
        check("req_valid", obs_req, exp_req);
        check("req_addr", obs_addr, m_pc);
        check("valid_dec", obs_vd, m_ifid.valid);
        check("instr_dec", obs_instr, m_ifid.instr);
        check("pc_dec", obs_pc, m_ifid.pc);
        check("pc_plus4_dec", obs_pc4, m_ifid.pc4);

        fire = exp_req && rdy;
        keep = 1'b0;
        ent  = BUBBLE;
        if (rsp) begin
            rsp_pc = m_infl.pop_front();
            void'(mem_q.pop_front());
            if (!rd) begin
                if (m_drop > 0) m_drop--;
                else begin
                    keep = 1'b1;
                    ent  = '{valid: 1'b1, instr: imem_rsp_data_i, pc: rsp_pc, pc4: rsp_pc + 32'd4};
                end
            end
        end

        if (fl) m_ifid = BUBBLE;
        else if (!sd) begin
            if (!rd && m_buf.size() > 0) m_ifid = m_buf.pop_front();
            else if (keep) begin
                m_ifid = ent;
                keep   = 1'b0;
            end else m_ifid = BUBBLE;
        end
        if (keep) m_buf.push_back(ent);

        if (rd) begin
            m_buf.delete();
            m_drop = m_infl.size();
            m_pc   = rpc;
        end else if (fire) begin
            m_infl.push_back(m_pc);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            mem_q.push_back('{addr: m_pc, due: due});
            m_pc = m_pc + 32'd4;
        end
        m_boot = 1'b0;

        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin : main
        bit          stall, found, seen_fffc, seen_zero;
        logic [31:0] addr_exp, rpc;

        drive_idle();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        model_reset();
        #1 check_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Stream start, then fetch+decode stall for three cycles.
        for (int i = 0; i < 12; i++) begin
            stall = (i >= 5 && i <= 7);
            cycle(stall, stall, 1'b0, 1'b0, 32'h0, 1'b1, 1);
            case (i)
                0: check("boot_no_req", obs_req, 32'h0);
                1: begin
                    check("first_req_valid", obs_req, 32'h1);
                    check("first_req_addr", obs_addr, 32'h0);
                end
                2: check("second_req_addr", obs_addr, 32'h4);
                3: begin
                    check("first_dec_valid", obs_vd, 32'h1);
                    check("first_dec_pc", obs_pc, 32'h0);
                    check("first_dec_instr", obs_instr, 32'h0010_0093);
                    check("first_dec_pc4", obs_pc4, 32'h4);
                end
                5, 6, 7: begin
                    check("stall_hold_pc", obs_pc, 32'h8);
                    check("stall_addr_frozen", obs_addr, 32'h10);
                    check("stall_no_req", obs_req, 32'h0);
                end
                8:  check("post_stall_pc_a", obs_pc, 32'h8);
                9:  check("post_stall_pc_b", obs_pc, 32'hC);
                10: check("post_stall_pc_c", obs_pc, 32'h10);
                default: ;
            endcase
        end

        // Redirect to 0x100 with latency-3 memory and requests in flight.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 3);
        check("redirect_no_req", obs_req, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
            if (i == 0) begin
                check("flush_bubble_valid", obs_vd, 32'h0);
                check("flush_bubble_instr", obs_instr, NOP);
                check("redirect_addr", obs_addr, 32'h100);
            end
            if (obs_vd && !found) begin
                found = 1'b1;
                check("redirect_first_pc", obs_pc, 32'h100);
                check("redirect_first_instr", obs_instr, 32'h0010_0193);
            end
        end
        check("redirect_target_seen", found, 32'h1);

        // Drain everything, then hold memory not-ready for five cycles.
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
        addr_exp = m_pc;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1);
            check("notready_req_held", obs_req, 32'h1);
            check("notready_addr_stable", obs_addr, addr_exp);
            check("notready_bubble_instr", obs_instr, NOP);
            check("notready_bubble_valid", obs_vd, 32'h0);
        end

        // Address wrap at the top of the address space.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1);
        seen_fffc = 1'b0;
        seen_zero = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
            if (obs_req && obs_addr == 32'h0) seen_zero = 1'b1;
            if (obs_vd && obs_pc == 32'hFFFF_FFFC && !seen_fffc) begin
                seen_fffc = 1'b1;
                check("wrap_pc_plus4", obs_pc4, 32'h0);
            end
        end
        check("wrap_last_word_seen", seen_fffc, 32'h1);
        check("wrap_addr_zero_seen", seen_zero, 32'h1);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            logic r_rd;
            r_rd = ($urandom_range(0, 99) < 4);
            rpc  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hC))
                                               : ($urandom() & 32'hFFFF_FFFC);
            cycle(($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 15),
                  r_rd || ($urandom_range(0, 99) < 5), r_rd, rpc,
                  ($urandom_range(0, 99) < 75), $urandom_range(1, 3));
        end

        // Reset while draining stale responses.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midreset");
        drive_idle();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1);
            if (i == 1) check("restart_req_addr", obs_addr, RESET_PC);
            if (i == 3) begin
                check("restart_dec_valid", obs_vd, 32'h1);
                check("restart_dec_pc", obs_pc, RESET_PC);
                check("restart_dec_instr", obs_instr, 32'h0010_0093);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
